// File: rtl/dircc_debug_ocimem_ctrl_pkg.sv
// dircc_ocimem_pkg: FSM states, jdo field positions and limits shared by the debug memory controller.
package dircc_ocimem_pkg;
    typedef enum logic [1:0] {IDLE, J_RD, C_RD, C_ACK} state_t;
    localparam int JDO_RDREQ_BIT = 35;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_WDATA_MSB = 34;
    localparam int JDO_WDATA_LSB = 3;
    localparam int ADDR_W_MAX    = 17;
endpackage

// File: rtl/dircc_debug_ocimem_ctrl_ram.sv
// dircc_ocimem_ram: single-port 32-bit RAM, byte-enable write, registered read, array never reset.
module dircc_ocimem_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_q
);
    logic [31:0] r_mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (i_we && i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        o_q <= r_mem[i_addr];
    end
endmodule

// File: rtl/dircc_debug_ocimem_ctrl.sv
// dircc_debug_ocimem_ctrl: JTAG/CPU arbiter for the debug RAM; DIRCC_OCIMEM_CPU_WRITE_PROTECT_EN gates CPU writes on debugaccess.
module dircc_debug_ocimem_ctrl
    import dircc_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    input  logic              debugaccess,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              jtag_overrun
);
    state_t            r_state, w_state_n;
    logic              r_rd_pend, r_wr_pend;
    logic [ADDR_W-1:0] r_jaddr, w_jaddr, w_jaddr_n, w_ram_addr;
    logic [31:0]       r_wdata, w_wr_data, w_ram_wdata, w_q;
    logic [3:0]        w_ram_be;
    logic              w_idle, w_cpu_req, w_cpu_we, w_rd_pulse, w_wr_req, w_rd_req;
    logic              w_gnt_wr, w_gnt_rd, w_gnt_cpu, w_drop, w_ram_we, w_unused;

    assign w_idle     = r_state == IDLE;
    assign w_cpu_req  = avs_read | avs_write;
    assign w_rd_pulse = take_no_action_ocimem_a | (take_action_ocimem_a & jdo[JDO_RDREQ_BIT]);
    // Pulses are served in their own cycle when idle, so the address and data come straight from jdo
    assign w_jaddr    = take_action_ocimem_a ? jdo[JDO_ADDR_LSB +: ADDR_W] : r_jaddr;
    assign w_wr_data  = r_wr_pend ? r_wdata : jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
    assign w_wr_req   = r_wr_pend | take_action_ocimem_b;
    assign w_rd_req   = r_rd_pend | w_rd_pulse;
    assign w_gnt_wr   = w_idle & w_wr_req;
    assign w_gnt_rd   = w_idle & !w_wr_req & w_rd_req;
    assign w_gnt_cpu  = w_idle & !w_wr_req & !w_rd_req & w_cpu_req;
    assign w_drop     = (take_action_ocimem_b & r_wr_pend & !w_gnt_wr) |
                        (w_rd_pulse & r_rd_pend & !w_gnt_rd);
    assign w_jaddr_n  = (r_state == J_RD && !take_action_ocimem_a) ? r_jaddr + 1'b1 :
                        w_gnt_wr ? w_jaddr + 1'b1 : w_jaddr;

`ifdef DIRCC_OCIMEM_CPU_WRITE_PROTECT_EN
    assign w_cpu_we = avs_write & debugaccess;
    assign w_unused = ^{jdo[37:36], jdo[2:0]};
`else
    assign w_cpu_we = avs_write;
    assign w_unused = ^{jdo[37:36], jdo[2:0], debugaccess};
`endif

    assign w_ram_we    = w_gnt_wr | (w_gnt_cpu & w_cpu_we);
    assign w_ram_be    = w_gnt_wr ? 4'hF : avs_byteenable;
    assign w_ram_addr  = w_gnt_cpu ? avs_address : w_jaddr;
    assign w_ram_wdata = w_gnt_wr ? w_wr_data : avs_writedata;

    assign avs_waitrequest = w_cpu_req & (r_state != C_ACK);

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:    w_state_n = w_gnt_rd ? J_RD : w_gnt_cpu ? (avs_write ? C_ACK : C_RD) : IDLE;
            C_RD:    w_state_n = C_ACK;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_rd_pend    <= 1'b0;
            r_wr_pend    <= 1'b0;
            r_jaddr      <= '0;
            r_wdata      <= '0;
            MonDReg      <= '0;
            avs_readdata <= '0;
            jtag_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_wr_pend <= w_gnt_wr ? (r_wr_pend & take_action_ocimem_b) : (r_wr_pend | take_action_ocimem_b);
            r_rd_pend <= w_gnt_rd ? (r_rd_pend & w_rd_pulse) : (r_rd_pend | w_rd_pulse);
            r_jaddr   <= w_jaddr_n;
            if (take_action_ocimem_b && !(r_wr_pend && !w_gnt_wr)) r_wdata <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
            if (r_state == J_RD) MonDReg <= w_q;
            if (r_state == C_RD) avs_readdata <= w_q;
            if (w_drop) jtag_overrun <= 1'b1;
        end
    end

    dircc_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_be    (w_ram_be),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_q     (w_q)
    );
endmodule

// File: tb/tb_dircc_debug_ocimem_ctrl.sv
// tb_dircc_debug_ocimem_ctrl: directed JTAG/CPU sequences with an expected-value queue for read results.
module tb_dircc_debug_ocimem_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0, take_no_action_ocimem_a = 1'b0, take_action_ocimem_b = 1'b0;
    logic [7:0]  avs_address = '0;
    logic        avs_read = 1'b0, avs_write = 1'b0, debugaccess = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [3:0]  avs_byteenable = '0;
    logic [31:0] avs_readdata, MonDReg;
    logic        avs_waitrequest, jtag_overrun;

    typedef struct { string tag; logic [31:0] val; } exp_t;
    exp_t sb[$];
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    dircc_debug_ocimem_ctrl #(.ADDR_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .debugaccess(debugaccess), .avs_readdata(avs_readdata),
        .avs_waitrequest(avs_waitrequest), .MonDReg(MonDReg), .jtag_overrun(jtag_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
        else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    function automatic logic [37:0] a_d(input logic rd, input logic [7:0] a);
        return (38'(rd) << 35) | (38'(a) << 17);
    endfunction

    function automatic logic [37:0] b_d(input logic [31:0] d);
        return 38'(d) << 3;
    endfunction

    // one-cycle JTAG pulse driven from a negedge, followed by `gap` idle cycles
    task automatic pulse(input logic a, input logic na, input logic b, input logic [37:0] d, input int gap);
        jdo = d;
        take_action_ocimem_a = a;
        take_no_action_ocimem_a = na;
        take_action_ocimem_b = b;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // CPU access; optional JTAG ocimem_b pulse in the same first cycle (jdo preloaded by caller)
    task automatic cpu(input string tag, input logic wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic da, input logic pb, input int exp_lat);
        int lat = 0;
        avs_address = a;
        avs_write = wr;
        avs_read = !wr;
        avs_writedata = d;
        avs_byteenable = be;
        debugaccess = da;
        take_action_ocimem_b = pb;
        #1;
        while (avs_waitrequest && lat < 20) begin
            @(negedge clk);
            take_action_ocimem_b = 1'b0;
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (!wr) pop_chk(avs_readdata);
        @(negedge clk);
        avs_read = 1'b0;
        avs_write = 1'b0;
        take_action_ocimem_b = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    localparam logic [31:0] PROT_EXP =
`ifdef DIRCC_OCIMEM_CPU_WRITE_PROTECT_EN
        32'hFFFF5678;
`else
        32'h0BADF00D;
`endif

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_readdata", avs_readdata, 32'h0);
        chk("rst_overrun", 32'(jtag_overrun), 32'h0);
        chk("rst_waitreq", 32'(avs_waitrequest), 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        pulse(1, 0, 0, a_d(0, 8'h10), 5);
        pulse(0, 0, 1, b_d(32'hDEADBEEF), 5);
        push("jtag_rd_0x10", 32'hDEADBEEF);
        pulse(1, 0, 0, a_d(1, 8'h10), 0);
        chk("jtag_rd_early", MonDReg, 32'h0);
        @(negedge clk);
        pop_chk(MonDReg);
        repeat (4) @(negedge clk);
        pulse(0, 0, 1, b_d(32'hCAFEF00D), 5);
        push("cpu_rd_0x11", 32'hCAFEF00D);
        cpu("cpu_rd_0x11", 0, 8'h11, '0, 4'hF, 1, 0, 2);
        push("cpu_rd_0x10", 32'hDEADBEEF);
        cpu("cpu_rd_0x10", 0, 8'h10, '0, 4'hF, 1, 0, 2);

        pulse(1, 0, 0, a_d(0, 8'hFF), 5);
        pulse(0, 0, 1, b_d(32'hAAAA0001), 5);
        pulse(0, 0, 1, b_d(32'hBBBB0002), 5);
        push("wrap_0xff", 32'hAAAA0001);
        cpu("wrap_0xff", 0, 8'hFF, '0, 4'hF, 1, 0, 2);
        push("wrap_0x00", 32'hBBBB0002);
        cpu("wrap_0x00", 0, 8'h00, '0, 4'hF, 1, 0, 2);

        cpu("cpu_wr_0x20", 1, 8'h20, 32'h11111111, 4'hF, 1, 0, 1);
        pulse(1, 0, 0, a_d(0, 8'h20), 5);
        jdo = b_d(32'h22222222);
        push("collide_0x20", 32'h22222222);
        cpu("collide_0x20", 0, 8'h20, '0, 4'hF, 1, 1, 3);
        repeat (4) @(negedge clk);

        pulse(1, 0, 0, a_d(0, 8'h30), 5);
        pulse(0, 0, 1, b_d(32'hFFFFFFFF), 5);
        cpu("cpu_wr_be", 1, 8'h30, 32'h12345678, 4'b0011, 1, 0, 1);
        push("jtag_rd_be", 32'hFFFF5678);
        pulse(1, 0, 0, a_d(1, 8'h30), 5);
        pop_chk(MonDReg);

        chk("overrun_pre", 32'(jtag_overrun), 32'h0);
        avs_address = 8'h30;
        avs_read = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        avs_read = 1'b0;
        push("overrun_cpu_rd", 32'hFFFF5678);
        pop_chk(avs_readdata);
        repeat (2) @(negedge clk);
        chk("overrun_set", 32'(jtag_overrun), 32'h1);
        repeat (10) @(negedge clk);
        chk("overrun_sticky", 32'(jtag_overrun), 32'h1);

        cpu("prot_wr", 1, 8'h30, 32'h0BADF00D, 4'hF, 0, 0, 1);
        push("prot_rd", PROT_EXP);
        cpu("prot_rd", 0, 8'h30, '0, 4'hF, 1, 0, 2);

        avs_address = 8'h30;
        avs_read = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        avs_read = 1'b0;
        #1;
        chk("mid_rst_mondreg", MonDReg, 32'h0);
        chk("mid_rst_readdata", avs_readdata, 32'h0);
        chk("mid_rst_overrun", 32'(jtag_overrun), 32'h0);
        chk("mid_rst_waitreq", 32'(avs_waitrequest), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        push("post_rst_rd", PROT_EXP);
        cpu("post_rst_rd", 0, 8'h30, '0, 4'hF, 1, 0, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
